// File: rtl/mult_pkg.sv
// Shared constants, state encoding and the operand-gating helper for the
// sequential 16x16 shift-and-add multiplier.
package mult_pkg;

  localparam int WIDTH     = 16;
  localparam int CNT_W     = 5;
  localparam int ADD_GRP   = 4;
  localparam logic [CNT_W-1:0] LAST_ITER = 5'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Partial product for one iteration: the multiplicand when the current
  // multiplier bit is set, otherwise zero.
  function automatic logic [WIDTH-1:0] gate_operand(input logic [WIDTH-1:0] op,
                                                    input logic sel);
    logic [WIDTH-1:0] res;
    if (sel) begin
      res = op;
    end else begin
      res = {WIDTH{1'b0}};
    end
    return res;
  endfunction

endpackage

// File: rtl/add_16.sv
// 16-bit adder built from 4-bit carry-lookahead groups whose group carries
// ripple from one group to the next.
module add_16
  import mult_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);

  localparam int NGRP = WIDTH / ADD_GRP;

  logic [WIDTH-1:0] w_g;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_c;
  logic [NGRP:0]    w_gc;

  assign w_g     = a & b;
  assign w_p     = a ^ b;
  assign w_gc[0] = c_in;

  // Each group resolves its internal carries in parallel from the group carry-in.
  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    logic [ADD_GRP-1:0] w_gg;
    logic [ADD_GRP-1:0] w_pp;
    logic               w_ci;

    assign w_gg = w_g[gi*ADD_GRP +: ADD_GRP];
    assign w_pp = w_p[gi*ADD_GRP +: ADD_GRP];
    assign w_ci = w_gc[gi];

    assign w_c[gi*ADD_GRP+0] = w_ci;
    assign w_c[gi*ADD_GRP+1] = w_gg[0] | (w_pp[0] & w_ci);
    assign w_c[gi*ADD_GRP+2] = w_gg[1] | (w_pp[1] & w_gg[0])
                             | (w_pp[1] & w_pp[0] & w_ci);
    assign w_c[gi*ADD_GRP+3] = w_gg[2] | (w_pp[2] & w_gg[1])
                             | (w_pp[2] & w_pp[1] & w_gg[0])
                             | (w_pp[2] & w_pp[1] & w_pp[0] & w_ci);
    assign w_gc[gi+1]        = w_gg[3] | (w_pp[3] & w_gg[2])
                             | (w_pp[3] & w_pp[2] & w_gg[1])
                             | (w_pp[3] & w_pp[2] & w_pp[1] & w_gg[0])
                             | (&w_pp & w_ci);
  end

  assign s     = w_p ^ w_c;
  assign c_out = w_gc[NGRP];

endmodule

// File: rtl/seq_shift_add_mult_16.sv
// Sequential 16x16 unsigned shift-and-add multiplier: one add and one
// right-shift of {A,Q} per cycle, 32-bit product after 16 iterations.
module seq_shift_add_mult_16
  import mult_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_a;
  logic               r_c;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic               r_busy;
  logic               r_done;

  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;

  assign w_addend = gate_operand(r_m, r_q[0]);

  // C is cleared on load and after every shift, so the carry-in is always zero.
  add_16 u_add (
    .a     (r_a),
    .b     (w_addend),
    .c_in  (r_c),
    .s     (w_sum),
    .c_out (w_cout)
  );

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_m       <= {WIDTH{1'b0}};
      r_q       <= {WIDTH{1'b0}};
      r_a       <= {WIDTH{1'b0}};
      r_c       <= 1'b0;
      r_cnt     <= {CNT_W{1'b0}};
      r_product <= {(2*WIDTH){1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= a;
            r_q     <= b;
            r_a     <= {WIDTH{1'b0}};
            r_c     <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // The adder carry-out shifts into A[15] rather than being dropped.
          r_a   <= {w_cout, w_sum[WIDTH-1:1]};
          r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          r_c   <= 1'b0;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == LAST_ITER) begin
            r_product <= {w_cout, w_sum, r_q[WIDTH-1:1]};
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_done    <= 1'b0;
            r_state   <= ST_RUN;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign product = r_product;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule
